// File: rtl/axi_pwm_slave_if.sv
// AXI4-Lite bus bundle for the PWM register block.
// Ports: aw/w/b write channels, ar/r read channels; master and slave views.
interface axi_pwm_slave_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_pwm_slave.sv
// AXI4-Lite register slave driving a complementary PWM pair with dead time.
// Ports: s00_axi_aclk/aresetn (sync, active-low), s00_axi bus (slave view),
//        pwm_h/pwm_l outputs, pwm_period_irq one-cycle wrap pulse.
module axi_pwm_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int C_PWM_WIDTH        = 16,
    parameter int C_DT_WIDTH         = 8
) (
    input  logic           s00_axi_aclk,
    input  logic           s00_axi_aresetn,
    axi_pwm_slave_if.slave s00_axi,
    output logic           pwm_h,
    output logic           pwm_l,
    output logic           pwm_period_irq
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int NB = DW / 8;
    localparam int PW = C_PWM_WIDTH;
    localparam int TW = C_DT_WIDTH;

    logic [C_S_AXI_ADDR_WIDTH-1:0] waddr;
    logic [C_S_AXI_ADDR_WIDTH-1:0] raddr;
    logic [1:0] wsel;
    logic [1:0] rsel;
    logic       unused_ok;

    logic          awready_q, awready_d;
    logic          bvalid_q, bvalid_d;
    logic          arready_q, arready_d;
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [DW-1:0] regs_q [4];
    logic [DW-1:0] regs_d [4];
    logic          wr_en;
    logic          rd_en;

    logic [PW-1:0] period_sh_q, period_sh_d;
    logic [PW-1:0] duty_sh_q, duty_sh_d;
    logic [TW-1:0] dt_sh_q, dt_sh_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] dtc_q, dtc_d;
    logic [TW-1:0] dt_rem;
    logic          raw_q, raw;
    logic          pwm_h_q, pwm_h_d;
    logic          pwm_l_q, pwm_l_d;
    logic          irq_q, irq_d;
    logic          en, inv, wrap, load, dt_done;

    assign waddr = s00_axi.awaddr;
    assign raddr = s00_axi.araddr;
    assign wsel  = waddr[3:2];
    assign rsel  = raddr[3:2];
    assign unused_ok = ^{s00_axi.awprot, s00_axi.arprot,
                         waddr[1:0], raddr[1:0]};

    // Bus side: one outstanding write and one outstanding read.
    always_comb begin
        regs_d    = regs_q;
        awready_d = 1'b0;
        arready_d = 1'b0;
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;

        wr_en = awready_q && s00_axi.awvalid && s00_axi.wvalid;
        rd_en = arready_q && s00_axi.arvalid;

        if (s00_axi.awvalid && s00_axi.wvalid &&
            !awready_q && !bvalid_q)
            awready_d = 1'b1;

        for (int b = 0; b < NB; b++) begin
            if (wr_en && s00_axi.wstrb[b])
                regs_d[wsel][b*8 +: 8] = s00_axi.wdata[b*8 +: 8];
        end

        if (bvalid_q && s00_axi.bready) bvalid_d = 1'b0;
        if (wr_en) bvalid_d = 1'b1;

        if (s00_axi.arvalid && !arready_q && !rvalid_q)
            arready_d = 1'b1;

        if (rvalid_q && s00_axi.rready) rvalid_d = 1'b0;
        // Reads sample the pre-write register contents.
        if (rd_en) begin
            rvalid_d = 1'b1;
            rdata_d  = regs_q[rsel];
        end
    end

    // PWM core runs from shadow copies refreshed at period boundaries.
    always_comb begin
        en   = regs_q[0][0];
        inv  = regs_q[0][1];
        wrap = en && (cnt_q == period_sh_q);
        load = !en || wrap;

        period_sh_d = load ? regs_q[1][PW-1:0] : period_sh_q;
        duty_sh_d   = load ? regs_q[2][PW-1:0] : duty_sh_q;
        dt_sh_d     = load ? regs_q[3][TW-1:0] : dt_sh_q;

        cnt_d = load ? '0 : cnt_q + 1'b1;
        raw   = cnt_q < duty_sh_q;

        // Dead-time counter reloads on every raw edge.
        dt_rem  = (raw != raw_q) ? dt_sh_q : dtc_q;
        dt_done = (dt_rem == '0);
        if (!en)
            dtc_d = regs_q[3][TW-1:0];
        else if (dt_done)
            dtc_d = '0;
        else
            dtc_d = dt_rem - 1'b1;

        pwm_h_d = (en && raw && dt_done) ^ inv;
        pwm_l_d = (en && !raw && dt_done) ^ inv;
        irq_d   = wrap;
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            awready_q   <= 1'b0;
            bvalid_q    <= 1'b0;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            regs_q      <= '{default: '0};
            period_sh_q <= '0;
            duty_sh_q   <= '0;
            dt_sh_q     <= '0;
            cnt_q       <= '0;
            dtc_q       <= '0;
            raw_q       <= 1'b0;
            pwm_h_q     <= 1'b0;
            pwm_l_q     <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            awready_q   <= awready_d;
            bvalid_q    <= bvalid_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            regs_q      <= regs_d;
            period_sh_q <= period_sh_d;
            duty_sh_q   <= duty_sh_d;
            dt_sh_q     <= dt_sh_d;
            cnt_q       <= cnt_d;
            dtc_q       <= dtc_d;
            raw_q       <= raw;
            pwm_h_q     <= pwm_h_d;
            pwm_l_q     <= pwm_l_d;
            irq_q       <= irq_d;
        end
    end

    assign s00_axi.awready = awready_q;
    assign s00_axi.wready  = awready_q;
    assign s00_axi.bresp   = 2'b00;
    assign s00_axi.bvalid  = bvalid_q;
    assign s00_axi.arready = arready_q;
    assign s00_axi.rdata   = rdata_q;
    assign s00_axi.rresp   = 2'b00;
    assign s00_axi.rvalid  = rvalid_q;

    assign pwm_h          = pwm_h_q;
    assign pwm_l          = pwm_l_q;
    assign pwm_period_irq = irq_q;
endmodule
